imem_loader: RTL and testbench

- Sequential program loader that fills the CPU's instruction memory before execution. It writes the instruction memory; the CPU core reads it.
- Accepts a byte stream (valid/ready) carrying a 16-bit word count followed by big-endian 32-bit instruction words.
- Writes each assembled word to instruction memory at consecutive word addresses.
- Holds the CPU via cpu_hold until the load completes.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_to_word_packer.sv | 45 ++++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        BYTE  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; first byte lands in [31:24].
module imem_loader_byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (accept) begin
            word_d = {word_q[23:0], in_data};
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    // Index wraps naturally to 0 after the last byte of a word.
    assign word_ready = accept && (idx_q == IDX_W'(WORD_BYTES - 1));
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a counted, big-endian word stream into instruction memory while holding the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded,
    output state_t      dbg_state
);

    // Stream handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [15:0] wl_q, wl_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pk_clear;
    logic        pk_accept;
    logic        word_ready;
    logic [15:0] hdr_n;
    logic [31:0] pk_word;

    assign hdr_n     = {cnt_q[15:8], in_data};
    assign pk_accept = in_valid && (state_q == BYTE);

    imem_loader_byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .accept     (pk_accept),
        .clear      (pk_clear),
        .in_data    (in_data),
        .word       (pk_word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wl_d     = wl_q;
        cnt_d    = cnt_q;
        pk_clear = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = HDR0;
                    wl_d     = '0;
                    ptr_d    = BASE_ADDR;
                    pk_clear = 1'b1;
                end
            end
            HDR0: begin
                if (in_valid) begin
                    cnt_d[15:8] = in_data;
                    state_d     = HDR1;
                end
            end
            HDR1: begin
                if (in_valid) begin
                    cnt_d = hdr_n;
                    if (hdr_n == 16'd0)             state_d = DONE;
                    else if ({1'b0, hdr_n} > MAX_W) state_d = ERR;
                    else                            state_d = BYTE;
                end
            end
            BYTE: begin
                if (word_ready) state_d = WRITE;
            end
            WRITE: begin
                ptr_d   = ptr_q + 32'd4;
                wl_d    = wl_q + 16'd1;
                state_d = (wl_d == cnt_q) ? DONE : BYTE;
            end
            ERR: state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= BASE_ADDR;
            wl_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wl_q    <= wl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = (state_q == HDR0) || (state_q == HDR1) || (state_q == BYTE);
    assign imem_we      = (state_q == WRITE);
    assign imem_addr    = ptr_q;
    assign imem_wdata   = pk_word;
    assign cpu_hold     = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);
    assign words_loaded = wl_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected memory writes are queued as stimulus is issued.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words [0:MAXW-1];

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst && imem_we) begin
      chk("we_in_ready_low", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h with empty queue", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e[63:32]);
        chk("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks; each is entered and left just after a falling edge
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int bound;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    in_valid = 1'b0;
    repeat (gap) cycle();
    in_valid = 1'b1;
    in_data = b;
    bound = 0;
    while (!in_ready && bound < 50) begin
      cycle();
      bound++;
    end
    if (bound >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: byte %h never accepted", b);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && !error && n < bound) begin
      cycle();
      n++;
    end
  endtask

  // reference model: word i of a load goes to BASE + 4*i
  task automatic run_load(input int n, input int max_gap, input bit mid_start);
    logic [31:0] nn;
    nn = n;
    pulse_start();
    send_byte(nn[15:8], max_gap);
    send_byte(nn[7:0], max_gap);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back({BASE + 32'(4 * i), words[i]});
        send_byte(words[i][31 - 8*b -: 8], max_gap);
      end
      if (mid_start && i == 0) pulse_start();
    end
    wait_done(20);
    chk("load_done", {31'd0, done}, 32'd1);
    chk("load_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("load_words_loaded", {16'd0, words_loaded}, nn & 32'hFFFF);
    chk("load_sb_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, BASE);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_reset_state("rst");

    pulse_start();
    chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
    words[0] = 32'h2408_0005;
    words[1] = 32'h0000_000C;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back({BASE + 32'(4 * i), words[i]});
        send_byte(words[i][31 - 8*b -: 8], 0);
      end
    wait_done(20);
    chk("fixed_done", {31'd0, done}, 32'd1);
    chk("fixed_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("fixed_words", {16'd0, words_loaded}, 32'd2);
    chk("fixed_sb_empty", exp_q.size(), 32'd0);

    // same stream with stalls, restarted from DONE
    run_load(2, 3, 1'b0);

    // empty load
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_done(2);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_words", {16'd0, words_loaded}, 32'd0);

    // randomized loads, some with an ignored mid-load start
    repeat (6) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_load(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // largest legal load
    for (int i = 0; i < MAXW; i++) words[i] = $urandom;
    run_load(MAXW, 0, 1'b0);

    // over-capacity header
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    cycle();
    chk("err_error", {31'd0, error}, 32'd1);
    chk("err_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("err_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (6) cycle();
    in_valid = 1'b0;
    chk("err_sticky", {31'd0, error}, 32'd1);
    chk("err_in_ready_after_start", {31'd0, in_ready}, 32'd0);
    do_reset();
    check_reset_state("err_rst");

    // abort a 3-word load after 6 data bytes
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) exp_q.push_back({BASE, words[0]});
      send_byte(words[k / 4][31 - 8*(k % 4) -: 8], 1);
    end
    do_reset();
    check_reset_state("abort");
    chk("abort_sb_empty", exp_q.size(), 32'd0);
    repeat (3) cycle();
    words[0] = $urandom;
    run_load(1, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
